// File: rtl/vproc_xif_result_order.sv
// Result-ordering stage for the XIF result channel: keeps offloaded instructions in issue order,
// tracks commit/kill, collects out-of-order unit results by id and emits results strictly in order.
module vproc_xif_result_order #(
    parameter int unsigned X_ID_WIDTH  = 3,
    parameter int unsigned X_RFW_WIDTH = 32,
    parameter int unsigned DEPTH       = 4
) (
    input  logic                        clk_i,
    input  logic                        async_rst_ni,

    input  logic                        issue_valid_i,
    input  logic                        issue_ready_i,
    input  logic                        issue_accept_i,
    input  logic                        issue_writeback_i,
    input  logic [X_ID_WIDTH-1:0]       issue_id_i,
    output logic                        issue_space_o,

    input  logic                        commit_valid_i,
    input  logic [X_ID_WIDTH-1:0]       commit_id_i,
    input  logic                        commit_kill_i,

    input  logic                        res_valid_i,
    input  logic [X_ID_WIDTH-1:0]       res_id_i,
    input  logic [X_RFW_WIDTH-1:0]      res_data_i,
    input  logic [4:0]                  res_rd_i,
    input  logic                        res_exc_i,
    input  logic [5:0]                  res_exccode_i,
    output logic                        res_drop_o,

    output logic                        result_valid_o,
    input  logic                        result_ready_i,
    output logic [X_ID_WIDTH-1:0]       result_id_o,
    output logic [X_RFW_WIDTH-1:0]      result_data_o,
    output logic [4:0]                  result_rd_o,
    output logic [X_RFW_WIDTH/32-1:0]   result_we_o,
    output logic                        result_exc_o,
    output logic [5:0]                  result_exccode_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned WE_W  = X_RFW_WIDTH / 32;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0]  id;
        logic                   wb;
        logic                   committed;
        logic                   killed;
        logic                   done;
        logic [X_RFW_WIDTH-1:0] data;
        logic [4:0]             rd;
        logic                   exc;
        logic [5:0]             exccode;
    } entry_t;

    typedef enum logic [1:0] {
        HEAD_EMPTY,
        HEAD_KILL,
        HEAD_WAIT,
        HEAD_SEND
    } head_state_e;

    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    logic [DEPTH-1:0] live_q, live_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             drop_q, drop_d;

    head_state_e      head_state;
    entry_t           head_ent;
    logic             full;
    logic             push;
    logic             pop;
    logic             res_hit;
    logic             send;

    assign full = (cnt_q == CNT_W'(DEPTH));
    assign send = (head_state == HEAD_SEND);

    // Head state is a pure decode of the registered head entry.
    always_comb begin
        head_ent   = ent_q[head_q];
        head_state = HEAD_EMPTY;
        if (cnt_q != '0) begin
            if (head_ent.killed) begin
                head_state = HEAD_KILL;
            end else if (head_ent.committed && head_ent.done) begin
                head_state = HEAD_SEND;
            end else begin
                head_state = HEAD_WAIT;
            end
        end
    end

    always_comb begin
        ent_d   = ent_q;
        live_d  = live_q;
        head_d  = head_q;
        tail_d  = tail_q;
        res_hit = 1'b0;

        push = issue_valid_i & issue_ready_i & issue_accept_i & ~full;
        pop  = (head_state == HEAD_KILL) | (send & result_ready_i);

        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (commit_valid_i && live_q[i] && (ent_q[i].id == commit_id_i)) begin
                if (commit_kill_i) begin
                    ent_d[i].killed = 1'b1;
                end else begin
                    ent_d[i].committed = 1'b1;
                end
            end
        end

        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (res_valid_i && live_q[i] && !ent_q[i].killed && !ent_q[i].done &&
                (ent_q[i].id == res_id_i)) begin
                ent_d[i].data    = res_data_i;
                ent_d[i].rd      = res_rd_i;
                ent_d[i].exc     = res_exc_i;
                ent_d[i].exccode = res_exccode_i;
                ent_d[i].done    = 1'b1;
                res_hit          = 1'b1;
            end
        end

        // A commit may target the instruction being pushed in the same cycle.
        if (push) begin
            ent_d[tail_q]           = '0;
            ent_d[tail_q].id        = issue_id_i;
            ent_d[tail_q].wb        = issue_writeback_i;
            ent_d[tail_q].committed = commit_valid_i & ~commit_kill_i & (commit_id_i == issue_id_i);
            ent_d[tail_q].killed    = commit_valid_i &  commit_kill_i & (commit_id_i == issue_id_i);
            live_d[tail_q]          = 1'b1;
            tail_d                  = tail_q + PTR_W'(1);
        end

        if (pop) begin
            live_d[head_q] = 1'b0;
            head_d         = head_q + PTR_W'(1);
        end

        cnt_d  = cnt_q + CNT_W'(push) - CNT_W'(pop);
        drop_d = res_valid_i & ~res_hit;
    end

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            live_q <= '0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            drop_q <= 1'b0;
        end else begin
            ent_q  <= ent_d;
            live_q <= live_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            drop_q <= drop_d;
        end
    end

    // Result fields are zeroed outside SEND so idle and reset outputs read 0.
    assign issue_space_o    = ~full;
    assign res_drop_o       = drop_q;
    assign result_valid_o   = send;
    assign result_id_o      = send ? head_ent.id      : '0;
    assign result_data_o    = send ? head_ent.data    : '0;
    assign result_rd_o      = send ? head_ent.rd      : '0;
    assign result_exc_o     = send ? head_ent.exc     : 1'b0;
    assign result_exccode_o = send ? head_ent.exccode : '0;
    assign result_we_o      = {WE_W{send & head_ent.wb & ~head_ent.exc}};

endmodule

// File: tb/tb_vproc_xif_result_order.sv
// Self-checking bench for vproc_xif_result_order: directed scenarios plus randomized traffic
// compared each cycle against an issue-order queue model.
module tb_vproc_xif_result_order;

    localparam int unsigned DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        async_rst_ni;
    logic        issue_valid_i, issue_ready_i, issue_accept_i, issue_writeback_i;
    logic [2:0]  issue_id_i;
    logic        issue_space_o;
    logic        commit_valid_i, commit_kill_i;
    logic [2:0]  commit_id_i;
    logic        res_valid_i;
    logic [2:0]  res_id_i;
    logic [31:0] res_data_i;
    logic [4:0]  res_rd_i;
    logic        res_exc_i;
    logic [5:0]  res_exccode_i;
    logic        res_drop_o;
    logic        result_valid_o, result_ready_i;
    logic [2:0]  result_id_o;
    logic [31:0] result_data_o;
    logic [4:0]  result_rd_o;
    logic [0:0]  result_we_o;
    logic        result_exc_o;
    logic [5:0]  result_exccode_o;

    vproc_xif_result_order #(.X_ID_WIDTH(3), .X_RFW_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .async_rst_ni(async_rst_ni),
        .issue_valid_i(issue_valid_i), .issue_ready_i(issue_ready_i),
        .issue_accept_i(issue_accept_i), .issue_writeback_i(issue_writeback_i),
        .issue_id_i(issue_id_i), .issue_space_o(issue_space_o),
        .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
        .res_valid_i(res_valid_i), .res_id_i(res_id_i), .res_data_i(res_data_i),
        .res_rd_i(res_rd_i), .res_exc_i(res_exc_i), .res_exccode_i(res_exccode_i),
        .res_drop_o(res_drop_o),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .result_id_o(result_id_o), .result_data_o(result_data_o), .result_rd_o(result_rd_o),
        .result_we_o(result_we_o), .result_exc_o(result_exc_o), .result_exccode_o(result_exccode_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [2:0]  id;
        bit          wb, committed, killed, done;
        logic [31:0] data;
        logic [4:0]  rd;
        bit          exc;
        logic [5:0]  exccode;
    } ent_t;

    ent_t q[$];
    bit   exp_drop;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit head_sendable();
        return (q.size() > 0) && q[0].committed && q[0].done && !q[0].killed;
    endfunction

    function automatic bit in_q(logic [2:0] id);
        foreach (q[i]) if (q[i].id == id) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [2:0] other_id(logic [2:0] excl);
        logic [2:0] id = 3'($urandom);
        for (int k = 0; k < 16 && (in_q(id) || id == excl); k++) id = id + 3'd1;
        return id;
    endfunction

    task automatic compare();
        bit ev = head_sendable();
        check_eq("valid", 32'(result_valid_o), 32'(ev));
        if (ev) begin
            check_eq("id",      32'(result_id_o),      32'(q[0].id));
            check_eq("data",    result_data_o,         q[0].data);
            check_eq("rd",      32'(result_rd_o),      32'(q[0].rd));
            check_eq("we",      32'(result_we_o),      32'(q[0].wb && !q[0].exc));
            check_eq("exc",     32'(result_exc_o),     32'(q[0].exc));
            check_eq("exccode", 32'(result_exccode_o), 32'(q[0].exccode));
        end else begin
            check_eq("idle_id",   32'(result_id_o),   32'd0);
            check_eq("idle_data", result_data_o,      32'd0);
            check_eq("idle_we",   32'(result_we_o),   32'd0);
            check_eq("idle_exc",  32'(result_exc_o),  32'd0);
        end
        check_eq("space", 32'(issue_space_o), 32'(q.size() < DEPTH));
        check_eq("drop",  32'(res_drop_o),    32'(exp_drop));
    endtask

    // Applies one clock of the architectural rules to the in-order queue.
    task automatic model_update();
        bit   do_pop;
        bit   hit = 1'b0;
        int   n_pre = q.size();
        ent_t e;
        do_pop = (n_pre > 0) && (q[0].killed || (head_sendable() && result_ready_i));
        if (res_valid_i) begin
            foreach (q[i]) begin
                if (q[i].id == res_id_i && !q[i].killed && !q[i].done) begin
                    q[i].data = res_data_i; q[i].rd = res_rd_i;
                    q[i].exc = res_exc_i;   q[i].exccode = res_exccode_i;
                    q[i].done = 1'b1;       hit = 1'b1;
                end
            end
        end
        exp_drop = res_valid_i && !hit;
        if (commit_valid_i) begin
            foreach (q[i]) begin
                if (q[i].id == commit_id_i) begin
                    if (commit_kill_i) q[i].killed = 1'b1; else q[i].committed = 1'b1;
                end
            end
        end
        if (issue_valid_i && issue_ready_i && issue_accept_i && n_pre < DEPTH) begin
            e = '{id: issue_id_i, wb: issue_writeback_i, committed: 1'b0, killed: 1'b0,
                  done: 1'b0, data: 32'd0, rd: 5'd0, exc: 1'b0, exccode: 6'd0};
            if (commit_valid_i && commit_id_i == issue_id_i) begin
                if (commit_kill_i) e.killed = 1'b1; else e.committed = 1'b1;
            end
            q.push_back(e);
        end
        if (do_pop) void'(q.pop_front());
    endtask

    task automatic tick();
        @(posedge clk_i);
        if (!async_rst_ni) begin
            q.delete();
            exp_drop = 1'b0;
        end else begin
            model_update();
        end
        @(negedge clk_i);
        compare();
    endtask

    task automatic idle();
        issue_valid_i = 1'b0; issue_ready_i = 1'b1; issue_accept_i = 1'b1; issue_writeback_i = 1'b1;
        commit_valid_i = 1'b0; commit_kill_i = 1'b0;
        res_valid_i = 1'b0; res_exc_i = 1'b0; res_exccode_i = '0; res_rd_i = '0; res_data_i = '0;
    endtask

    task automatic issue(input logic [2:0] id, input logic wb);
        issue_valid_i = 1'b1; issue_id_i = id; issue_writeback_i = wb;
    endtask

    task automatic commit(input logic [2:0] id, input logic kill);
        commit_valid_i = 1'b1; commit_id_i = id; commit_kill_i = kill;
    endtask

    task automatic result(input logic [2:0] id, input logic [31:0] data, input logic exc,
                          input logic [5:0] code);
        res_valid_i = 1'b1; res_id_i = id; res_data_i = data; res_rd_i = 5'(id);
        res_exc_i = exc; res_exccode_i = code;
    endtask

    task automatic rand_cycle();
        logic [2:0] nid;
        logic [2:0] cand[$];
        bit         wp;
        idle();
        issue_valid_i     = 1'($urandom_range(0, 1));
        issue_ready_i     = ($urandom_range(0, 3) != 0);
        issue_accept_i    = ($urandom_range(0, 7) != 0) && (q.size() < DEPTH);
        issue_writeback_i = 1'($urandom_range(0, 1));
        nid = 3'($urandom);
        for (int k = 0; k < 16 && in_q(nid); k++) nid = nid + 3'd1;
        issue_id_i = nid;
        wp = issue_valid_i && issue_ready_i && issue_accept_i;
        foreach (q[i]) if (!q[i].committed && !q[i].killed) cand.push_back(q[i].id);
        if (wp) cand.push_back(nid);
        commit_valid_i = 1'($urandom_range(0, 1));
        commit_kill_i  = ($urandom_range(0, 4) == 0);
        if (cand.size() > 0 && $urandom_range(0, 3) != 0)
            commit_id_i = cand[$urandom_range(0, cand.size() - 1)];
        else
            commit_id_i = other_id(nid);
        res_valid_i = 1'($urandom_range(0, 1));
        if (q.size() > 0 && $urandom_range(0, 3) != 0)
            res_id_i = q[$urandom_range(0, q.size() - 1)].id;
        else
            res_id_i = other_id(nid);
        res_data_i     = $urandom;
        res_rd_i       = 5'($urandom);
        res_exc_i      = ($urandom_range(0, 4) == 0);
        res_exccode_i  = 6'($urandom);
        result_ready_i = ($urandom_range(0, 2) != 0);
    endtask

    initial begin
        async_rst_ni = 1'b0;
        idle();
        issue_id_i = '0; commit_id_i = '0; res_id_i = '0;
        result_ready_i = 1'b1;
        exp_drop = 1'b0;
        repeat (2) tick();
        async_rst_ni = 1'b1;

        // In-order delivery despite out-of-order results
        idle(); issue(3'd1, 1'b1); tick();
        idle(); issue(3'd2, 1'b1); tick();
        idle(); commit(3'd1, 1'b0); tick();
        idle(); commit(3'd2, 1'b0); result_ready_i = 1'b0; result(3'd2, 32'hB, 1'b0, 6'd0); tick();
        idle(); result(3'd1, 32'hA, 1'b0, 6'd0); tick();
        idle();
        check_eq("t1_first_id",   32'(result_id_o), 32'd1);
        check_eq("t1_first_data", result_data_o,    32'hA);
        check_eq("t1_first_we",   32'(result_we_o), 32'd1);
        result_ready_i = 1'b1; tick();
        check_eq("t1_second_id",   32'(result_id_o), 32'd2);
        check_eq("t1_second_data", result_data_o,    32'hB);
        tick();
        check_eq("t1_empty", 32'(result_valid_o), 32'd0);

        // Killed instruction: no result, late unit result dropped
        idle(); issue(3'd3, 1'b1); tick();
        idle(); commit(3'd3, 1'b1); tick();
        idle(); result(3'd3, 32'h33, 1'b0, 6'd0); tick();
        check_eq("t2_drop", 32'(res_drop_o), 32'd1);
        idle(); tick();
        check_eq("t2_drop_pulse", 32'(res_drop_o), 32'd0);
        check_eq("t2_no_valid",   32'(result_valid_o), 32'd0);

        // Full queue and slot release
        for (int k = 0; k < 4; k++) begin
            idle(); issue(3'(k), 1'b1); tick();
        end
        check_eq("t3_full", 32'(issue_space_o), 32'd0);
        idle(); commit(3'd0, 1'b0); result(3'd0, 32'h100, 1'b0, 6'd0); tick();
        check_eq("t3_send_full", 32'(issue_space_o), 32'd0);
        idle(); tick();
        check_eq("t3_freed", 32'(issue_space_o), 32'd1);
        for (int k = 1; k < 4; k++) begin
            idle(); commit(3'(k), 1'b1); tick();
        end
        idle(); repeat (2) tick();

        // Backpressure holds the SEND outputs
        idle(); issue(3'd4, 1'b1); tick();
        idle(); commit(3'd4, 1'b0); tick();
        idle(); result_ready_i = 1'b0; result(3'd4, 32'h44, 1'b0, 6'd0); tick();
        idle();
        for (int k = 0; k < 5; k++) begin
            check_eq("t4_hold_valid", 32'(result_valid_o), 32'd1);
            check_eq("t4_hold_id",    32'(result_id_o),    32'd4);
            check_eq("t4_hold_data",  result_data_o,       32'h44);
            tick();
        end
        result_ready_i = 1'b1;
        check_eq("t4_sixth_valid", 32'(result_valid_o), 32'd1);
        tick();
        check_eq("t4_popped", 32'(result_valid_o), 32'd0);

        // Exception suppresses write enable
        idle(); issue(3'd5, 1'b1); tick();
        idle(); commit(3'd5, 1'b0); tick();
        idle(); result(3'd5, 32'h55, 1'b1, 6'd5); tick();
        idle();
        check_eq("t5_exc",     32'(result_exc_o),     32'd1);
        check_eq("t5_exccode", 32'(result_exccode_o), 32'd5);
        check_eq("t5_we",      32'(result_we_o),      32'd0);
        tick();

        // Asynchronous reset with a result pending
        result_ready_i = 1'b0;
        idle(); issue(3'd1, 1'b1); tick();
        idle(); issue(3'd2, 1'b1); commit(3'd1, 1'b0); tick();
        idle(); issue(3'd3, 1'b1); result(3'd1, 32'h11, 1'b0, 6'd0); tick();
        idle();
        check_eq("t6_pre_valid", 32'(result_valid_o), 32'd1);
        #2 async_rst_ni = 1'b0;
        #1;
        check_eq("t6_rst_valid", 32'(result_valid_o), 32'd0);
        check_eq("t6_rst_space", 32'(issue_space_o),  32'd1);
        q.delete();
        exp_drop = 1'b0;
        repeat (2) tick();
        async_rst_ni = 1'b1;
        result_ready_i = 1'b1;
        idle(); result(3'd1, 32'h11, 1'b0, 6'd0); tick();
        check_eq("t6_old_drop", 32'(res_drop_o), 32'd1);
        idle(); tick();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rand_cycle();
            tick();
        end
        idle(); result_ready_i = 1'b1;
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
